// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the capsule-layer MAC sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_BIAS,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_ACC    = 2'b00;
  localparam logic [1:0] MODE_LDMUL  = 2'b01;
  localparam logic [1:0] MODE_AFFINE = 2'b10;
  localparam logic [1:0] MODE_ADD    = 2'b11;

  localparam int unsigned LEN_8    = 8;
  localparam int unsigned LEN_16   = 16;
  localparam int unsigned LEN_1152 = 1152;

  // Reserved code 11 falls back to the shortest job.
  function automatic int unsigned len_decode(input logic [1:0] sel);
    case (sel)
      2'b01:   return LEN_16;
      2'b10:   return LEN_1152;
      default: return LEN_8;
    endcase
  endfunction

endpackage

// File: rtl/mac_seq_counter.sv
// Element counter with synchronous clear/enable and fixed-length compares.
module mac_seq_counter
  import mac_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             eq8,
  output logic             eq16,
  output logic             eq1152
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  assign eq8    = (count == CNT_W'(LEN_8));
  assign eq16   = (count == CNT_W'(LEN_16));
  assign eq1152 = (count == CNT_W'(LEN_1152));

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM sequencing clear, dot-product accumulate, optional bias and
// result capture for one MAC instance.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       len_sel,
  input  logic             bias_en,
  input  logic [1:0]       const_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in1_gate,
  output logic [1:0]       out_mode,
  output logic [1:0]       sel_mux4,
  output logic             sel1,
  output logic             ld_reg,
  output logic             en_cnt,
  output logic [CNT_W-1:0] count,
  output logic             eq8,
  output logic             eq16,
  output logic             eq1152,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [1:0]       cfg_len;
  logic [1:0]       cfg_cs;
  logic [CNT_W-1:0] last_idx;
  logic             last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_len <= '0;
      cfg_cs  <= '0;
    end else if (state == ST_IDLE && start) begin
      cfg_len <= len_sel;
      cfg_cs  <= const_sel;
    end
  end

  assign last_idx  = CNT_W'(len_decode(cfg_len) - 1);
  assign last_word = (count == last_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_CLEAR;
      ST_CLEAR:   state_nxt = ST_ACCUM;
      ST_ACCUM:   if (in_valid && last_word) state_nxt = bias_en ? ST_BIAS : ST_CAPTURE;
      ST_BIAS:    if (in_valid) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_mode = MODE_ACC;
    in_ready = 1'b0;
    sel1     = 1'b0;
    ld_reg   = 1'b0;
    done     = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_CLEAR:   out_mode = MODE_LDMUL;
      ST_ACCUM:   in_ready = 1'b1;
      ST_BIAS: begin
        out_mode = MODE_ADD;
        in_ready = 1'b1;
      end
      ST_CAPTURE: begin
        sel1   = 1'b1;
        ld_reg = 1'b1;
      end
      ST_DONE:    done = 1'b1;
      default:    ;
    endcase
  end

  // Gating in1 on stalls keeps the accumulator frozen without a mode change.
  assign in1_gate = in_ready & in_valid;
  assign en_cnt   = (state == ST_ACCUM) & in_valid;
  assign sel_mux4 = cfg_cs;

  mac_seq_counter #(.CNT_W(CNT_W)) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_CLEAR),
    .en     (en_cnt),
    .count  (count),
    .eq8    (eq8),
    .eq16   (eq16),
    .eq1152 (eq1152)
  );

endmodule
